lcd_frame_streamer: RTL and testbench
=====================================

Name: lcd_frame_streamer

Overview:
- Parametrised successor to the fixed-width LCD data-store block.
- Holds a ROWS x COLS character buffer and streams a full HD44780 frame as PCF8574 I2C payload bytes in 4-bit mode, one byte per valid/ready handshake.
- Sits between the sensor/formatting logic, which writes characters, and the I2C byte master, which consumes tx_data.
- Replaces the wide parallel output buses with a byte stream.

Parameters:
- COLS, 16, characters per row (1..40)
- ROWS, 2, display rows (1..4)
- BL, 1, backlight bit value driven on every payload byte

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- wr_en  in  1  character write strobe
- wr_addr  in  $clog2(ROWS*COLS)  character index, row*COLS+col
- wr_data  in  8  ASCII code
- start  in  1  request frame transmission (level sampled per cycle)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- tx_valid  out  1  payload byte available
- tx_data  out  8  payload byte {nibble[3:0], BL, EN, RW=0, RS}
- tx_ready  in  1  consumer accepts byte

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports named clk and rst.
- Reset values:
  - busy=0, done=0, tx_valid=0, tx_data=8'h00, state=IDLE.
  - All buffer entries = 8'h20 (space).
- Writes:
  - wr_en with wr_addr < ROWS*COLS updates the buffer the next edge, in any state.
  - Out-of-range addresses are ignored.
- Transfers:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - tx_data is held stable while tx_valid && !tx_ready.
  - tx_valid never drops without a transfer.
- States and transitions:
  - IDLE: start=1 -> CMD with row=0, phase=0; busy=1 and tx_valid=1 from the next cycle.
  - CMD: LCD byte = 8'h80 | row_base, RS=0. Row bases: 0x00, 0x40, 0x14, 0x54. After phase 3 transfers -> CHAR with col=0.
  - CHAR: LCD byte = buffer[row*COLS+col], RS=1. The character is latched when phase 0 is loaded. After phase 3 transfers: col+1, or at col=COLS-1 -> NEXT_ROW.
  - NEXT_ROW: row+1 -> CMD (no bubble required, one permitted), or at row=ROWS-1 -> DONE.
  - DONE: busy=0, done=1 for exactly one cycle, tx_valid=0 -> IDLE.
- Nibble phases per LCD byte (4 payload bytes):
  - phase0: {hi, BL, 1, 0, RS}
  - phase1: {hi, BL, 0, 0, RS}
  - phase2: {lo, BL, 1, 0, RS}
  - phase3: {lo, BL, 0, 0, RS}
- Frame length: ROWS*(COLS+1)*4 bytes (136 at defaults).
- start while busy is ignored; no queuing.
- Write to a character during busy:
  - Visible in this frame if it lands before that character's phase-0 load.
  - Otherwise visible in the next frame.
- Reset mid-frame aborts immediately to the reset values, buffer included.
- tx_ready held low indefinitely stalls the stream with no state change.

Optional Feature:
- Macro LCD_DIRTY_ROWS_EN.
- Defined:
  - A per-row dirty bit is set by any in-range write to that row and cleared when the row's CMD phase 0 is loaded.
  - Clean rows are skipped entirely, with no CMD and no chars.
  - All dirty bits are set at reset.
  - If start arrives with no dirty rows: busy=1 for one cycle, then done pulses, zero bytes emitted.
  - A write to a row during its own transmission re-sets its dirty bit.
- Undefined: every start sends all rows; no dirty logic exists.

Test Plan:
- After reset, start pulse with tx_ready=1 -> 136 bytes; first four 0x8C,0x88,0x0C,0x08; each char 0x2D,0x29,0x0D,0x09; row1 command 0xCC,0xC8,0x0C,0x08; done pulses once the cycle after the last transfer.
- Write addr 0 = 0x4E ('N'), then start -> bytes 4..7 = 0x4D,0x49,0xED,0xE9.
- tx_ready toggled randomly, including holds of 10 cycles low -> tx_data stable during stalls; byte sequence identical to the tx_ready=1 run.
- start asserted repeatedly while busy -> exactly one frame emitted; done pulses once.
- Reset asserted after 50 transfers -> tx_valid/busy drop asynchronously; a subsequent start yields an all-space frame.
- With LCD_DIRTY_ROWS_EN: after the first full frame, write addr 17 (row1) then start -> 68 bytes, beginning 0xCC; start with nothing written -> done with zero bytes.

Source files
------------

// File: rtl/lcd_frame_streamer_if.sv
// rtl/lcd_frame_streamer_if.sv - byte stream between the LCD frame streamer and the I2C byte master
interface lcd_frame_streamer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/lcd_frame_streamer.sv
// rtl/lcd_frame_streamer.sv - ROWS x COLS character buffer streamed as HD44780 4-bit PCF8574 payload bytes
// Optional build macro LCD_DIRTY_ROWS_EN: only rows written since their last transmission are sent.
module lcd_frame_streamer #(
  parameter int COLS = 16,
  parameter int ROWS = 2,
  parameter bit BL   = 1'b1,
  localparam int DEPTH = ROWS * COLS,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  lcd_frame_streamer_if.master tx
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD      = 3'd1;
  localparam logic [2:0] S_CHAR     = 3'd2;
  localparam logic [2:0] S_NEXT_ROW = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]    state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [1:0]    phase_q;
  logic [7:0]    lcd_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    mem_q [DEPTH];

  logic          wr_ok;
  logic          xfer;
  logic          is_char;
  logic          last_col;
  logic          last_row;
  logic [AW-1:0] char_idx;
  logic [7:0]    cmd_byte;
  logic [ROWS-1:0] row_mask;
  int            seek_from;
  logic          seek_hit;
  logic [RW-1:0] seek_row;

  function automatic logic [7:0] payload(input logic [7:0] b, input logic [1:0] ph, input logic rs);
    logic [3:0] nib;
    nib = ph[1] ? b[3:0] : b[7:4];
    return {nib, BL, ~ph[0], 1'b0, rs};
  endfunction

  function automatic logic [7:0] row_base(input int r);
    case (r)
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  assign wr_ok    = wr_en && (int'(wr_addr) < DEPTH);
  assign xfer     = tx_valid_q && tx.tx_ready;
  assign is_char  = (state_q == S_CHAR);
  assign last_col = (int'(col_q) == COLS - 1);
  assign last_row = (int'(row_q) == ROWS - 1);
  assign cmd_byte = 8'h80 | row_base(int'(seek_row));

  // Index of the character loaded when the current LCD byte finishes.
  always_comb begin
    int idx;
    idx      = int'(row_q) * COLS + (is_char ? int'(col_q) + 1 : 0);
    char_idx = AW'(idx);
  end

`ifdef LCD_DIRTY_ROWS_EN
  logic [ROWS-1:0] dirty_q;
  logic [RW-1:0]   wr_row;
  assign wr_row   = RW'(int'(wr_addr) / COLS);
  assign row_mask = dirty_q;
`else
  assign row_mask = '1;
`endif

  // Lowest eligible row at or after seek_from; without dirty tracking every row is eligible.
  always_comb begin
    seek_from = (state_q == S_IDLE) ? 0 : int'(row_q) + 1;
    seek_hit  = 1'b0;
    seek_row  = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (i >= seek_from && row_mask[i]) begin
        seek_hit = 1'b1;
        seek_row = RW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      phase_q    <= '0;
      lcd_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h20;
`ifdef LCD_DIRTY_ROWS_EN
      dirty_q    <= '1;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_NEXT_ROW: begin
          if (state_q == S_NEXT_ROW || start) begin
            if (seek_hit) begin
              state_q    <= S_CMD;
              row_q      <= seek_row;
              phase_q    <= 2'd0;
              lcd_q      <= cmd_byte;
              tx_data_q  <= payload(cmd_byte, 2'd0, 1'b0);
              tx_valid_q <= 1'b1;
              busy_q     <= 1'b1;
`ifdef LCD_DIRTY_ROWS_EN
              dirty_q[seek_row] <= 1'b0;
`endif
            end else if (state_q == S_IDLE) begin
              // Nothing to send: spend one busy cycle, then finish with zero bytes.
              state_q <= S_NEXT_ROW;
              row_q   <= RW'(ROWS - 1);
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_CMD, S_CHAR: begin
          if (xfer) begin
            if (phase_q != 2'd3) begin
              phase_q   <= phase_q + 2'd1;
              tx_data_q <= payload(lcd_q, phase_q + 2'd1, is_char);
            end else if (!is_char || !last_col) begin
              state_q   <= S_CHAR;
              col_q     <= is_char ? col_q + CW'(1) : '0;
              phase_q   <= 2'd0;
              lcd_q     <= mem_q[char_idx];
              tx_data_q <= payload(mem_q[char_idx], 2'd0, 1'b1);
            end else if (last_row) begin
              state_q    <= S_DONE;
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q    <= S_NEXT_ROW;
              tx_valid_q <= 1'b0;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (wr_ok) mem_q[wr_addr] <= wr_data;
`ifdef LCD_DIRTY_ROWS_EN
      // Placed after the case so a write re-arms a row cleared on this same edge.
      if (wr_ok) dirty_q[wr_row] <= 1'b1;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// tb/tb_lcd_frame_streamer.sv - directed and randomized frame checks against a frame-level reference model
module tb_lcd_frame_streamer;
  localparam int COLS  = 16;
  localparam int ROWS  = 2;
  localparam int DEPTH = ROWS * COLS;
`ifdef LCD_DIRTY_ROWS_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;

  lcd_frame_streamer_if tx_if();

  lcd_frame_streamer #(.COLS(COLS), .ROWS(ROWS), .BL(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .tx      (tx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mbuf [DEPTH];
  bit         mdirty [ROWS];
  logic [7:0] rbase [4] = '{8'h00, 8'h40, 8'h14, 8'h54};
  logic [7:0] exp_q [$];
  logic [7:0] got [$];
  int done_cnt, done_cyc, last_xfer, busy_cyc;
  bit aborted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mbuf[i] = 8'h20;
    for (int r = 0; r < ROWS; r++) mdirty[r] = 1'b1;
  endtask

  task automatic push_lcd(input logic [7:0] b, input logic rs);
    logic [3:0] nib;
    for (int p = 0; p < 4; p++) begin
      nib = (p < 2) ? b[7:4] : b[3:0];
      exp_q.push_back({nib, 1'b1, (p % 2 == 0), 1'b0, rs});
    end
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      if (DIRTY && !mdirty[r]) continue;
      mdirty[r] = 1'b0;
      push_lcd(8'h80 | rbase[r], 1'b0);
      for (int c = 0; c < COLS; c++) push_lcd(mbuf[r * COLS + c], 1'b1);
    end
  endtask

  task automatic write_char(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mbuf[a] = d;
    mdirty[a / COLS] = 1'b1;
  endtask

  // Pulses start, then plays the byte consumer until done (or abort_after transfers).
  task automatic collect(input bit rand_ready, input bit noise, input int abort_after);
    bit held, rdy;
    logic [7:0] held_data;
    int hold_left, r;
    got.delete();
    done_cnt = 0; done_cyc = -1; last_xfer = -1; busy_cyc = 0;
    held = 1'b0; hold_left = 0; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    tx_if.tx_ready = 1'b0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      if (held) begin
        check("stall_valid", tx_if.tx_valid, 1);
        check("stall_data", tx_if.tx_data, held_data);
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
      if (!rand_ready) rdy = 1'b1;
      else if (hold_left > 0) begin
        rdy = 1'b0;
        hold_left--;
      end else begin
        r = $urandom_range(0, 7);
        if (r == 0) hold_left = 9;
        rdy = (r >= 3);
      end
      tx_if.tx_ready = rdy;
      start = (noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (tx_if.tx_valid && rdy) begin
        got.push_back(tx_if.tx_data);
        last_xfer = cyc;
        if (abort_after > 0 && got.size() == abort_after) begin
          aborted = 1'b1;
          start = 1'b0;
          return;
        end
      end
      held = tx_if.tx_valid && !rdy;
      held_data = tx_if.tx_data;
    end
    start = 1'b0;
    check("done_seen", done_cnt, 1);
  endtask

  task automatic quiet(input int n);
    int extra;
    extra = 0;
    tx_if.tx_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (done || tx_if.tx_valid || busy) extra++;
    end
    check("no_extra_activity", extra, 0);
  endtask

  task automatic compare_frame(input string tag);
    int n;
    check({tag, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    if (got.size() > 0) check({tag, "_done_timing"}, done_cyc, last_xfer + 1);
  endtask

  initial begin
    tx_if.tx_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", tx_if.tx_valid, 0);
    check("rst_data", tx_if.tx_data, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check("idle_valid", tx_if.tx_valid, 0);

    build_expected();
    collect(1'b0, 1'b0, 0);
    compare_frame("space_frame");
    check("frame_len_136", got.size(), 136);
    if (got.size() >= 72) begin
      check("cmd0_p0", got[0], 8'h8C); check("cmd0_p1", got[1], 8'h88);
      check("cmd0_p2", got[2], 8'h0C); check("cmd0_p3", got[3], 8'h08);
      check("space_p0", got[4], 8'h2D); check("space_p1", got[5], 8'h29);
      check("space_p2", got[6], 8'h0D); check("space_p3", got[7], 8'h09);
      check("cmd1_p0", got[68], 8'hCC); check("cmd1_p1", got[69], 8'hC8);
      check("cmd1_p2", got[70], 8'h0C); check("cmd1_p3", got[71], 8'h08);
    end
    quiet(20);

    write_char(0, 8'h4E);
    write_char(DEPTH - 1, 8'($urandom_range(33, 126)));
    build_expected();
    collect(1'b0, 1'b0, 0);
    compare_frame("n_frame");
    if (got.size() >= 8) begin
      check("n_p0", got[4], 8'h4D); check("n_p1", got[5], 8'h49);
      check("n_p2", got[6], 8'hED); check("n_p3", got[7], 8'hE9);
    end
    quiet(20);

    for (int k = 0; k < 3; k++) begin
      repeat (6) write_char($urandom_range(0, DEPTH - 1), 8'($urandom_range(32, 126)));
      write_char(DEPTH - 1, 8'($urandom_range(32, 126)));
      build_expected();
      collect(1'b1, 1'b1, 0);
      compare_frame($sformatf("rand_frame%0d", k));
      quiet(30);
    end

    write_char(DEPTH - 1, 8'h41);
    write_char(3, 8'h42);
    build_expected();
    collect(1'b1, 1'b0, 50);
    check("abort_reached", aborted, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_valid", tx_if.tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", tx_if.tx_data, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    build_expected();
    collect(1'b0, 1'b0, 0);
    compare_frame("post_reset_frame");
    quiet(20);

`ifdef LCD_DIRTY_ROWS_EN
    write_char(17, 8'($urandom_range(32, 126)));
    build_expected();
    collect(1'b0, 1'b0, 0);
    compare_frame("dirty_row1");
    check("dirty_row1_len", got.size(), 68);
    if (got.size() > 0) check("dirty_row1_first", got[0], 8'hCC);
    quiet(20);
    build_expected();
    collect(1'b0, 1'b0, 0);
    check("clean_len", got.size(), 0);
    check("clean_busy_cycles", busy_cyc, 1);
    quiet(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
